// File: rtl/mgmt_ram_arb_pkg.sv
// Shared types and address-decode constants for the management RAM arbiter.
package mgmt_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int WORD_ADDR_LSB = 2;
    localparam int BLK_IDX_LSB   = 10;
    localparam int BLK_IDX_W     = 8;
    localparam int WORD_ADDR_W   = BLK_IDX_LSB - WORD_ADDR_LSB;

endpackage

// File: rtl/mgmt_ram_rr_picker.sv
// Two-requester round-robin picker; a burst hold keeps the last owner while it still requests.
module mgmt_ram_rr_picker (
    input  logic [1:0] i_req,
    input  logic [1:0] i_last_grant,
    input  logic       i_burst_hold,
    output logic [1:0] o_grant
);

    // i_last_grant is always one-hot, so its inverse is the other requester.
    always_comb begin
        o_grant = 2'b00;
        if (i_burst_hold && (|(i_req & i_last_grant))) begin
            o_grant = i_last_grant;
        end else if (i_req == 2'b11) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req;
        end
    end

endmodule

// File: rtl/mgmt_ram_arbiter.sv
// Shares the management RAM port between two Wishbone classic requesters (IDLE/ACCESS/RESP).
// Optional owner bursts are enabled by defining MGMT_RAM_ARB_BURST_EN.
module mgmt_ram_arbiter
    import mgmt_ram_arb_pkg::*;
#(
    parameter int RAM_BLOCKS = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [3:0]               m0_sel_i,
    input  logic [31:0]              m0_adr_i,
    input  logic [31:0]              m0_dat_i,
    output logic                     m0_ack_o,
    output logic [31:0]              m0_dat_o,
    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [3:0]               m1_sel_i,
    input  logic [31:0]              m1_adr_i,
    input  logic [31:0]              m1_dat_i,
    output logic                     m1_ack_o,
    output logic [31:0]              m1_dat_o,
    output logic [RAM_BLOCKS-1:0]    mgmt_ena,
    output logic [RAM_BLOCKS-1:0]    mgmt_wen,
    output logic [RAM_BLOCKS*4-1:0]  mgmt_wen_mask,
    output logic [WORD_ADDR_W-1:0]   mgmt_addr,
    output logic [31:0]              mgmt_wdata,
    input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata,
    output logic [1:0]               arb_grant
);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [WORD_ADDR_W-1:0] r_word;
    logic [BLK_IDX_W-1:0]   r_blk;
    logic                   r_we;
    logic [3:0]             r_sel;
    logic [31:0]            r_dat;
    logic [1:0]             r_grant;
    logic [1:0]             r_last;

    logic [1:0]  w_req;
    logic [1:0]  w_pick;
    logic        w_burst_hold;
    logic        w_accept;
    logic [31:0] w_adr;
    logic        w_hit;
    logic [31:0] w_rdata_blk;
    logic [31:0] w_rd_dat;
    logic        w_unused_adr;

    assign w_req    = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_accept = (r_state == IDLE) && (|w_req);
    assign w_adr    = w_pick[1] ? m1_adr_i : m0_adr_i;

    assign w_unused_adr = ^{m0_adr_i[31:BLK_IDX_LSB+BLK_IDX_W], m0_adr_i[WORD_ADDR_LSB-1:0],
                            m1_adr_i[31:BLK_IDX_LSB+BLK_IDX_W], m1_adr_i[WORD_ADDR_LSB-1:0]};

    mgmt_ram_rr_picker u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last),
        .i_burst_hold (w_burst_hold),
        .o_grant      (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_blk   <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_dat   <= 32'h0;
            r_grant <= 2'b00;
            r_last  <= 2'b10;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_word  <= w_adr[BLK_IDX_LSB-1:WORD_ADDR_LSB];
                r_blk   <= w_adr[BLK_IDX_LSB +: BLK_IDX_W];
                r_we    <= w_pick[1] ? m1_we_i  : m0_we_i;
                r_sel   <= w_pick[1] ? m1_sel_i : m0_sel_i;
                r_dat   <= w_pick[1] ? m1_dat_i : m0_dat_i;
                r_grant <= w_pick;
            end
            if (r_state == RESP) begin
                r_last <= r_grant;
            end
        end
    end

    // A block index only matches a loop index below RAM_BLOCKS, so out-of-range never hits.
    always_comb begin
        mgmt_ena      = '0;
        mgmt_wen      = '0;
        mgmt_wen_mask = '0;
        mgmt_addr     = '0;
        mgmt_wdata    = 32'h0;
        w_hit         = 1'b0;
        w_rdata_blk   = 32'h0;
        for (int b = 0; b < RAM_BLOCKS; b++) begin
            if (r_blk == BLK_IDX_W'(b)) begin
                w_hit       = 1'b1;
                w_rdata_blk = mgmt_rdata[32*b +: 32];
                if (r_state == ACCESS) begin
                    mgmt_ena[b]            = 1'b1;
                    mgmt_wen[b]            = r_we;
                    mgmt_wen_mask[4*b +: 4] = r_we ? r_sel : 4'h0;
                end
            end
        end
        if (r_state == ACCESS) begin
            mgmt_addr  = r_word;
            mgmt_wdata = r_dat;
        end
    end

    assign w_rd_dat  = (w_hit && !r_we) ? w_rdata_blk : 32'h0;
    assign m0_ack_o  = (r_state == RESP) && !r_grant[1] && m0_cyc_i;
    assign m1_ack_o  = (r_state == RESP) &&  r_grant[1] && m1_cyc_i;
    assign m0_dat_o  = m0_ack_o ? w_rd_dat : 32'h0;
    assign m1_dat_o  = m1_ack_o ? w_rd_dat : 32'h0;
    assign arb_grant = r_grant;

`ifdef MGMT_RAM_ARB_BURST_EN
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    logic [BEAT_W-1:0] r_beats;
    logic              r_cyc_held;
    logic              w_owner_cyc;
    logic              w_last_cyc;

    assign w_owner_cyc  = r_grant[1] ? m1_cyc_i : m0_cyc_i;
    assign w_last_cyc   = r_last[1]  ? m1_cyc_i : m0_cyc_i;
    assign w_burst_hold = r_cyc_held && w_last_cyc && (r_beats < BEAT_W'(MAX_BURST));

    // r_cyc_held remembers that the previous owner kept its cycle open through RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beats    <= '0;
            r_cyc_held <= 1'b0;
        end else begin
            if (r_state == RESP) begin
                r_cyc_held <= w_owner_cyc;
            end else if ((r_state == IDLE) && !w_last_cyc) begin
                r_cyc_held <= 1'b0;
            end
            if (w_accept) begin
                r_beats <= (w_burst_hold && (w_pick == r_last)) ? r_beats + 1'b1 : BEAT_W'(1);
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_burst_hold = 1'b0;
    assign w_unused_cfg = (MAX_BURST > 0);
`endif

endmodule
